// File: rtl/clock_ratio_meter_pkg.sv
// ---------------------------------------------------------------------------
// clock_ratio_meter_pkg
//   Shared definitions for the clock ratio meter and the divider it observes.
//   - crm_state_e      : measurement FSM encoding (IDLE=0, ARM=1, MEASURE=2)
//   - LOCK_CNT_WIDTH   : width of the lock match counter (LOCK_COUNT <= 15)
//   - lock_sat_inc()   : saturating increment for the match counter
// ---------------------------------------------------------------------------
package clock_ratio_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } crm_state_e;

  localparam int LOCK_CNT_WIDTH = 4;

  // Increment v but never beyond lim.
  function automatic logic [LOCK_CNT_WIDTH-1:0] lock_sat_inc(
    input logic [LOCK_CNT_WIDTH-1:0] v,
    input logic [LOCK_CNT_WIDTH-1:0] lim
  );
    if (v >= lim) begin
      return lim;
    end
    return v + LOCK_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/clock_ratio_meter_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
//   Brings an asynchronous level into the clk domain through two flops and
//   keeps one history flop so both edges can be detected on the synchronized
//   level. Detection latency is fixed at 2-3 clk cycles.
//   Ports:
//     clk      in  : sampling clock (posedge)
//     resetb   in  : asynchronous active-low reset
//     async_in in  : asynchronous input level
//     level    out : synchronized level (second flop)
//     rise     out : one-cycle pulse on synchronized rising edge
//     fall     out : one-cycle pulse on synchronized falling edge
// ---------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk,
  input  logic resetb,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// ---------------------------------------------------------------------------
// clock_ratio_meter
//   Measures a divided clock in units of the fast clock: rising-edge to
//   rising-edge period, sampled high time, a lock flag once the period has
//   repeated LOCK_COUNT times, and a sticky timeout when no rising edge is
//   seen within 2^WIDTH-1 cycles.
//   Parameters:
//     WIDTH      : counter/output width, also sets the timeout limit
//     LOCK_COUNT : consecutive equal periods needed for lock (1..15)
//   Ports:
//     clk       in  : fast reference clock
//     resetb    in  : asynchronous active-low reset
//     sig_in    in  : divided clock under measurement (asynchronous)
//     enable    in  : measurement enable; low returns the FSM to IDLE
//     clear_err in  : pulse clearing the sticky timeout
//     period    out : clk cycles between the last two rising edges
//     high_time out : clk cycles sampled high in the last complete high phase
//     valid     out : one-cycle pulse when period updates
//     locked    out : period stable for LOCK_COUNT measurements
//     timeout   out : sticky, no rising edge within 2^WIDTH-1 cycles
// ---------------------------------------------------------------------------
module clock_ratio_meter
  import clock_ratio_meter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  // All-ones is both the saturation point and the timeout threshold.
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [LOCK_CNT_WIDTH-1:0] LOCK_LIMIT = LOCK_CNT_WIDTH'(LOCK_COUNT);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic sig_level, sig_rise, sig_fall;

  sync_edge_detect u_sync (
    .clk      (clk),
    .resetb   (resetb),
    .async_in (sig_in),
    .level    (sig_level),
    .rise     (sig_rise),
    .fall     (sig_fall)
  );

  crm_state_e                state_q, state_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          hcnt_q, hcnt_d;
  logic [WIDTH-1:0]          wait_q, wait_d;
  logic [WIDTH-1:0]          period_q, period_d;
  logic [WIDTH-1:0]          high_time_q, high_time_d;
  logic                      valid_q, valid_d;
  logic                      locked_q, locked_d;
  logic                      timeout_q, timeout_d;
  logic [LOCK_CNT_WIDTH-1:0] match_q, match_d;
  // Set once a period has been captured in the current MEASURE run, so the
  // first capture after ARM is never compared against a stale period.
  logic                      has_prev_q, has_prev_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    wait_d      = wait_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    match_d     = match_q;
    has_prev_d  = has_prev_q;
    locked_d    = (match_q >= LOCK_LIMIT);
    // A timeout raised below overrides this clear in the same cycle.
    timeout_d   = timeout_q & ~clear_err;

    if (!enable) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      hcnt_d     = '0;
      wait_d     = '0;
      match_d    = '0;
      has_prev_d = 1'b0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d      = '0;
          hcnt_d     = '0;
          wait_d     = '0;
          match_d    = '0;
          has_prev_d = 1'b0;
          locked_d   = 1'b0;
          state_d    = ST_ARM;
        end

        ST_ARM: begin
          if (sig_rise) begin
            cnt_d      = CNT_ONE;
            hcnt_d     = CNT_ONE;
            wait_d     = '0;
            has_prev_d = 1'b0;
            state_d    = ST_MEASURE;
          end else if (wait_q == CNT_MAX) begin
            timeout_d = 1'b1;
            wait_d    = '0;
            match_d   = '0;
            locked_d  = 1'b0;
          end else begin
            wait_d = wait_q + CNT_ONE;
          end
        end

        ST_MEASURE: begin
          // A rise coinciding with saturation still counts as a rise.
          if (sig_rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            hcnt_d   = CNT_ONE;
            if (has_prev_q && (cnt_q == period_q)) begin
              match_d = lock_sat_inc(match_q, LOCK_LIMIT);
            end else begin
              match_d = '0;
            end
            has_prev_d = 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d  = 1'b1;
            locked_d   = 1'b0;
            match_d    = '0;
            has_prev_d = 1'b0;
            cnt_d      = '0;
            hcnt_d     = '0;
            wait_d     = '0;
            state_d    = ST_ARM;
          end else begin
            cnt_d = sat_inc(cnt_q);
            if (sig_level) begin
              hcnt_d = sat_inc(hcnt_q);
            end
          end
          if (sig_fall) begin
            high_time_d = hcnt_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      wait_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      match_q     <= '0;
      has_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      wait_q      <= wait_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      match_q     <= match_d;
      has_prev_q  <= has_prev_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// ---------------------------------------------------------------------------
// tb_clock_ratio_meter
//   Directed bench for clock_ratio_meter (WIDTH=8, LOCK_COUNT=2). sig_in is
//   generated in half-clock steps offset 1 time unit from the clock edges.
//   Each driven rising edge that closes a period pushes the expected
//   period/high-time/lock result; a monitor pops and compares on valid.
// ---------------------------------------------------------------------------
module tb_clock_ratio_meter;

  localparam int WIDTH = 8;

  logic             clk       = 1'b0;
  logic             resetb    = 1'b1;
  logic             sig_in    = 1'b0;
  logic             enable    = 1'b0;
  logic             clear_err = 1'b0;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  clock_ratio_meter #(.WIDTH(WIDTH), .LOCK_COUNT(2)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .sig_in    (sig_in),
    .enable    (enable),
    .clear_err (clear_err),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int p;
    int lo;
    int hi;
    bit lk;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   lock_chk_pend = 1'b0;
  bit   lock_exp      = 1'b0;

  // Period generated but not yet closed by the next rising edge.
  bit pend_ok = 1'b0;
  int pend_p  = 0;
  int pend_lo = 0;
  int pend_hi = 0;
  // Lock model: consecutive equal periods since the last arm.
  bit have_prev = 1'b0;
  int prev_p    = 0;
  int exp_match = 0;

  time t_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic rearm();
    pend_ok   = 1'b0;
    have_prev = 1'b0;
    exp_match = 0;
  endtask

  task automatic push_exp(input int p, input int lo, input int hi);
    exp_t e;
    if (have_prev && p == prev_p) begin
      exp_match = (exp_match >= 2) ? 2 : exp_match + 1;
    end else begin
      exp_match = 0;
    end
    have_prev = 1'b1;
    prev_p    = p;
    e.p  = p;
    e.lo = lo;
    e.hi = hi;
    e.lk = (exp_match >= 2);
    sb_q.push_back(e);
  endtask

  // One sig_in period: rise, hh half-cycles high, hl half-cycles low.
  task automatic gen_period(input int hh, input int hl, input int lo, input int hi);
    sig_in = 1'b1;
    if (pend_ok) push_exp(pend_p, pend_lo, pend_hi);
    #(5 * hh);
    sig_in = 1'b0;
    #(5 * hl);
    pend_ok = 1'b1;
    pend_p  = (hh + hl) / 2;
    pend_lo = lo;
    pend_hi = hi;
  endtask

  task automatic align();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !lock_chk_pend) done = 1'b1;
    end
    n_cmp++;
    assert (done) else begin
      n_mis++;
      $error("FAIL drain: %0d results outstanding after %0d cycles, expected 0",
             sb_q.size(), budget);
      sb_q.delete();
      lock_chk_pend = 1'b0;
    end
  endtask

  // Monitor: compare each valid against the scoreboard; check locked a cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (lock_chk_pend) begin
        chk("locked_after_valid", {31'd0, locked}, {31'd0, lock_exp});
        lock_chk_pend = 1'b0;
      end
      if (valid === 1'b1) begin
        $display("valid: period=%0d high_time=%0d expected_queue=%0d",
                 period, high_time, sb_q.size());
        n_cmp++;
        assert (sb_q.size() != 0) else begin
          n_mis++;
          $error("FAIL unexpected_valid: observed valid with period=%0d, expected no valid", period);
        end
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("period", 32'(period), mon_e.p);
          n_cmp++;
          assert (int'(high_time) >= mon_e.lo && int'(high_time) <= mon_e.hi) else begin
            n_mis++;
            $error("FAIL high_time: observed %0d expected %0d..%0d",
                   high_time, mon_e.lo, mon_e.hi);
          end
          lock_exp      = mon_e.lk;
          lock_chk_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    // Reset state
    #1 resetb = 1'b0;
    #2;
    chk("rst_period",    32'(period),    0);
    chk("rst_high_time", 32'(high_time), 0);
    chk("rst_valid",     {31'd0, valid},   0);
    chk("rst_locked",    {31'd0, locked},  0);
    chk("rst_timeout",   {31'd0, timeout}, 0);
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    #1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rearm();

    // Divide-by-2, then divide-by-5 with edges on both clock phases
    repeat (6) gen_period(2, 2, 1, 1);
    repeat (6) gen_period(5, 5, 2, 3);

    // Divide-by-4 switching to divide-by-6 while locked
    repeat (5) gen_period(4, 4, 2, 2);
    repeat (5) gen_period(6, 6, 3, 3);

    // Last rise, then sig_in stuck low: timeout after 255 cycles in MEASURE
    t_r = $time;
    sig_in = 1'b1;
    push_exp(pend_p, pend_lo, pend_hi);
    pend_ok = 1'b0;
    #30;
    sig_in = 1'b0;
    #((t_r + 2460) - $time);
    chk("timeout_not_yet", {31'd0, timeout}, 0);
    #200;
    chk("timeout_set",      {31'd0, timeout}, 1);
    chk("timeout_unlocked", {31'd0, locked},  0);
    chk("timeout_period",   32'(period),      6);
    #340;
    chk("timeout_sticky",   {31'd0, timeout}, 1);
    clear_err = 1'b1;
    #10;
    clear_err = 1'b0;
    chk("timeout_cleared",  {31'd0, timeout}, 0);
    rearm();

    // Enable dropped mid-period, then re-enabled
    repeat (4) gen_period(4, 4, 2, 2);
    sig_in = 1'b1;
    push_exp(pend_p, pend_lo, pend_hi);
    pend_ok = 1'b0;
    #20;
    sig_in = 1'b0;
    wait_drain(20);
    #1;
    enable = 1'b0;
    #20;
    chk("idle_locked",    {31'd0, locked}, 0);
    chk("idle_period",    32'(period),     4);
    chk("idle_high_time", 32'(high_time),  2);
    #30;
    enable = 1'b1;
    #30;
    rearm();
    repeat (5) gen_period(4, 4, 2, 2);

    // Divide-by-3 until locked, then asynchronous reset mid-MEASURE
    repeat (4) gen_period(3, 3, 1, 2);
    wait_drain(20);
    chk("locked_before_reset", {31'd0, locked}, 1);
    #2;
    resetb = 1'b0;
    #1;
    chk("mid_rst_period",    32'(period),      0);
    chk("mid_rst_high_time", 32'(high_time),   0);
    chk("mid_rst_valid",     {31'd0, valid},   0);
    chk("mid_rst_locked",    {31'd0, locked},  0);
    chk("mid_rst_timeout",   {31'd0, timeout}, 0);
    #20;
    align();
    resetb = 1'b1;
    rearm();
    repeat (3) @(negedge clk);
    #1;
    repeat (4) gen_period(3, 3, 1, 2);
    pend_ok = 1'b0;
    wait_drain(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
Measures a divided clock, such as the output of the integer-N clock divider, in units of the fast source clock. It reports period, high time, a lock indication and a timeout error. It closes the loop on the divider: firmware or test logic reads back the effective divide ratio and checks that the divider has settled after an N change. The block is single clock domain; the measured signal is treated as asynchronous and is synchronized internally.

Parameters:
WIDTH, 8, width of the period/high-time counters and outputs; also sets the timeout at 2^WIDTH-1 cycles.
LOCK_COUNT, 2, number of consecutive measurements equal to their predecessor required before locked asserts (legal range 1..15).

Ports:
clk  input  1  fast reference clock (same clock that feeds the divider); all logic on posedge.
resetb  input  1  asynchronous active-low reset.
sig_in  input  1  divided clock under measurement; asynchronous to clk.
enable  input  1  measurement enable; low forces IDLE.
clear_err  input  1  single-cycle pulse; clears sticky timeout.
period  output  WIDTH  clk cycles between the last two sig_in rising edges.
high_time  output  WIDTH  clk cycles sig_in was sampled high in the last complete high phase.
valid  output  1  one-cycle pulse when period is updated.
locked  output  1  period has been stable for LOCK_COUNT consecutive measurements.
timeout  output  1  sticky flag: no rising edge seen within 2^WIDTH-1 cycles.

Behaviour:
- Reset values: period=0, high_time=0, valid=0, locked=0, timeout=0, state=IDLE, all counters and synchronizer flops 0.
- Input synchronizer:
  - Two-flop synchronizer s1→s2, plus history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Fixed 2–3 cycle detection latency; this cancels out in period and high_time.
- State machine, 2-bit:
  - IDLE: counters held at 0, valid=0, locked=0, match_cnt=0. Go to ARM when enable=1.
  - ARM: wait for the first rise; no measurement is produced. On rise: cnt<=1, hcnt<=1, go to MEASURE.
  - MEASURE: each cycle cnt<=cnt+1, saturating at all-ones.
    - hcnt increments each cycle while s2=1, saturating.
    - On fall: high_time<=hcnt.
    - On rise: period<=cnt, valid=1 next cycle, cnt<=1, hcnt<=1.
  - enable low in any state: go to IDLE next cycle. period and high_time hold their last values; timeout holds.
- Period arithmetic: rises at cycles t and t+P give period=P. Divide-by-2 gives 2; divide-by-7 gives 7.
- High time: the divider's even outputs give high_time=N/2. Odd-N outputs have a 50% duty with half-cycle edges, so the sampled high_time may read (N-1)/2 or (N+1)/2 and may alternate. high_time is excluded from the lock criterion.
- Lock:
  - On each valid, compare the new period with the previous captured period.
  - Equal: match_cnt increments, saturating at LOCK_COUNT. Unequal: match_cnt<=0.
  - locked = (match_cnt >= LOCK_COUNT), registered; it updates the cycle after valid.
  - The first measurement after ARM has no predecessor and never increments match_cnt.
- Timeout:
  - In MEASURE, if cnt reaches all-ones without a rise: timeout<=1, locked<=0, match_cnt<=0, go to ARM. period is not updated.
  - In ARM, a separate wait counter of equal width applies the same rule.
  - timeout clears only on clear_err or reset. If clear_err and a new timeout occur in the same cycle, the new timeout wins.
- Simultaneous events: rise together with counter saturation is treated as a rise, not a timeout. clear_err has no effect on measurement.
- Divide-by-1 (sig_in == clk) cannot be resolved by sampling. The synchronizer sees a constant level, so the block times out by design.
- Reset asserted mid-measurement: all state returns to reset values immediately (asynchronous); no partial result is emitted.

Decomposition:
- State encodings (IDLE=0, ARM=1, MEASURE=2) go in the shared defines header alongside the existing clock-divider defines.
- Timeout limit is derived from WIDTH locally.
- One natural sub-module: sync_edge_detect (2-flop synchronizer plus history flop; outputs level, rise, fall; clk/resetb). It is reusable for other async inputs.
- Counters, lock and FSM stay in clock_ratio_meter.

Test Plan:
- Divide-by-2 stimulus (sig_in toggles every clk), enable=1 → period=2, high_time=1 on every valid; locked=1 one cycle after the 3rd valid with LOCK_COUNT=2.
- Divide-by-5 with 50% duty from both clock edges → period=5 on every valid; high_time in {2,3}; locked asserts and stays high.
- sig_in switches from divide-by-4 to divide-by-6 while locked → first valid shows period=6 and locked=0 next cycle; relocks after 2 further matching periods.
- sig_in held at 0 for 300 cycles with WIDTH=8 → timeout=1 after 255 cycles in MEASURE, locked=0, period keeps its old value; clear_err pulse → timeout=0.
- enable dropped mid-period then raised → no valid until the second rise after re-enable; period reports the correct value; locked rebuilds from 0.
- resetb asserted mid-MEASURE → all outputs 0 immediately; the first valid after release comes only after ARM plus one full period.
